// File: rtl/cic3_decim_ctrl.sv
// Sequencing controller for the 3rd-order CIC decimator.
// Ports: clk/reset, enable, dec_log2, cic_out, data_ready in;
//   cic_rst_n, divided_clk, data_out, data_valid, overrun, sample_cnt, state out.
module cic3_decim_ctrl #(
  parameter int SETTLE  = 3,
  parameter int CAP_DLY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  dec_log2,
  input  logic [24:0] cic_out,
  input  logic        data_ready,
  output logic        cic_rst_n,
  output logic        divided_clk,
  output logic [24:0] data_out,
  output logic        data_valid,
  output logic        overrun,
  output logic [15:0] sample_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } st_t;

  st_t        st_q, st_d;
  logic [3:0] d_eff;
  logic [3:0] dec_in;
  logic [7:0] cnt;
  logic [2:0] discard_cnt;
  logic [7:0] d_last;
  logic [7:0] d_half;
  logic [7:0] cap_pt;
  logic       active;
  logic       start;
  logic       strobe;
  logic       capture;
  logic       stay;

  assign state = st_q;

  always_comb begin
    dec_in = 4'd8;
    if (dec_log2 >= 4'd5 && dec_log2 <= 4'd8)
      dec_in = dec_log2;
  end

  always_comb begin
    d_last  = 8'((9'd1 << d_eff) - 9'd1);
    d_half  = 8'(9'd1 << (d_eff - 4'd1));
    cap_pt  = d_half + 8'(CAP_DLY);
    active  = (st_q == S_SETTLE) || (st_q == S_RUN);
    start   = (st_q == S_IDLE) && enable;
    strobe  = active && (cnt == cap_pt);
    capture = strobe && (st_q == S_RUN);
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:   if (enable) st_d = S_SETTLE;
      S_SETTLE: if (discard_cnt == 3'(SETTLE)) st_d = S_RUN;
      S_RUN:    st_d = S_RUN;
      default:  st_d = S_IDLE;
    endcase
    if (!enable) st_d = S_IDLE;
  end

  // outputs that must read low in IDLE look at the next state
  assign stay = active && (st_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= S_IDLE;
      d_eff       <= 4'd8;
      cnt         <= 8'd0;
      discard_cnt <= 3'd0;
      cic_rst_n   <= 1'b0;
      divided_clk <= 1'b0;
      data_out    <= 25'd0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      sample_cnt  <= 16'd0;
    end else begin
      st_q        <= st_d;
      cic_rst_n   <= stay;
      divided_clk <= stay && (cnt >= d_half);

      if (start)
        d_eff <= dec_in;

      if (!stay)
        cnt <= 8'd0;
      else if (cnt == d_last)
        cnt <= 8'd0;
      else
        cnt <= cnt + 8'd1;

      if (start)
        discard_cnt <= 3'd0;
      else if (strobe && st_q == S_SETTLE &&
               discard_cnt != 3'(SETTLE))
        discard_cnt <= discard_cnt + 3'd1;

      if (start) begin
        data_out   <= 25'd0;
        data_valid <= 1'b0;
        overrun    <= 1'b0;
        sample_cnt <= 16'd0;
      end else if (capture) begin
        data_out   <= cic_out;
        data_valid <= 1'b1;
        sample_cnt <= sample_cnt + 16'd1;
        if (data_valid && !data_ready)
          overrun <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic3_decim_ctrl.sv
// Self-checking bench for cic3_decim_ctrl.
// Table vectors, a sample scoreboard and hand sequences.
module tb_cic3_decim_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  dec_log2;
  logic [24:0] cic_out;
  logic        data_ready;
  logic        rdy_z;

  logic        cic_rst_n, divided_clk, data_valid, overrun;
  logic [24:0] data_out;
  logic [15:0] sample_cnt;
  logic [1:0]  state;

  logic        cic_rst_n_z, divided_clk_z, data_valid_z, overrun_z;
  logic [24:0] data_out_z;
  logic [15:0] sample_cnt_z;
  logic [1:0]  state_z;

  always #5 clk = ~clk;

  cic3_decim_ctrl #(.SETTLE(3), .CAP_DLY(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .dec_log2(dec_log2), .cic_out(cic_out),
    .data_ready(data_ready),
    .cic_rst_n(cic_rst_n), .divided_clk(divided_clk),
    .data_out(data_out), .data_valid(data_valid),
    .overrun(overrun), .sample_cnt(sample_cnt),
    .state(state)
  );

  cic3_decim_ctrl #(.SETTLE(0), .CAP_DLY(4)) dut_z (
    .clk(clk), .reset(reset), .enable(enable),
    .dec_log2(dec_log2), .cic_out(cic_out),
    .data_ready(rdy_z),
    .cic_rst_n(cic_rst_n_z), .divided_clk(divided_clk_z),
    .data_out(data_out_z), .data_valid(data_valid_z),
    .overrun(overrun_z), .sample_cnt(sample_cnt_z),
    .state(state_z)
  );

  typedef struct {
    int          t;
    logic [1:0]  st;
    logic        dclk;
    logic        rstn;
    logic        vld;
    logic [24:0] dout;
    logic [15:0] scnt;
    logic        ovr;
  } vec_t;

  vec_t tbl [18];
  int   t;
  int   errors = 0;
  int   checks = 0;
  int   q [$];
  logic mv;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    cic_out = 25'(t);
  endtask

  task automatic start_run(input logic [3:0] d);
    dec_log2 = d;
    enable   = 1'b1;
    t        = -1;
    tick();
  endtask

  task automatic measure(output int per);
    int   t1;
    logic p;
    per = -1;
    t1  = -1;
    p   = divided_clk;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (divided_clk && !p) begin
        if (t1 < 0) t1 = i;
        else begin
          per = i - t1;
          break;
        end
      end
      p = divided_clk;
    end
  endtask

  initial begin
    int k;
    int per;
    logic strb;

    tbl[0]  = '{0,   2'd1, 1'b0, 1'b0, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[1]  = '{1,   2'd1, 1'b0, 1'b1, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[2]  = '{16,  2'd1, 1'b0, 1'b1, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[3]  = '{17,  2'd1, 1'b1, 1'b1, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[4]  = '{32,  2'd1, 1'b1, 1'b1, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[5]  = '{33,  2'd1, 1'b0, 1'b1, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[6]  = '{49,  2'd1, 1'b1, 1'b1, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[7]  = '{85,  2'd1, 1'b1, 1'b1, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[8]  = '{86,  2'd2, 1'b1, 1'b1, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[9]  = '{116, 2'd2, 1'b1, 1'b1, 1'b0, 25'd0,   16'd0, 1'b0};
    tbl[10] = '{117, 2'd2, 1'b1, 1'b1, 1'b1, 25'd116, 16'd1, 1'b0};
    tbl[11] = '{118, 2'd2, 1'b1, 1'b1, 1'b0, 25'd116, 16'd1, 1'b0};
    tbl[12] = '{149, 2'd2, 1'b1, 1'b1, 1'b1, 25'd148, 16'd2, 1'b0};
    tbl[13] = '{181, 2'd2, 1'b1, 1'b1, 1'b1, 25'd180, 16'd3, 1'b0};
    tbl[14] = '{212, 2'd2, 1'b1, 1'b1, 1'b1, 25'd180, 16'd3, 1'b0};
    tbl[15] = '{213, 2'd2, 1'b1, 1'b1, 1'b1, 25'd212, 16'd4, 1'b0};
    tbl[16] = '{244, 2'd2, 1'b1, 1'b1, 1'b1, 25'd212, 16'd4, 1'b0};
    tbl[17] = '{245, 2'd2, 1'b1, 1'b1, 1'b1, 25'd244, 16'd5, 1'b1};

    reset      = 1'b1;
    enable     = 1'b0;
    dec_log2   = 4'd5;
    cic_out    = 25'd0;
    data_ready = 1'b1;
    rdy_z      = 1'b1;
    t          = 0;
    repeat (3) tick();

    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rstn", 32'(cic_rst_n), 32'd0);
    chk("rst_dclk", 32'(divided_clk), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_vld", 32'(data_valid), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_scnt", 32'(sample_cnt), 32'd0);

    reset = 1'b0;
    tick();
    start_run(4'd5);

    k  = 0;
    mv = 1'b0;
    for (int c = 0; c <= 250; c++) begin
      if (c > 0) tick();
      if (k < 18 && tbl[k].t == t) begin
        chk("tbl_state", 32'(state), 32'(tbl[k].st));
        chk("tbl_dclk", 32'(divided_clk), 32'(tbl[k].dclk));
        chk("tbl_rstn", 32'(cic_rst_n), 32'(tbl[k].rstn));
        chk("tbl_vld", 32'(data_valid), 32'(tbl[k].vld));
        chk("tbl_dout", 32'(data_out), 32'(tbl[k].dout));
        chk("tbl_scnt", 32'(sample_cnt), 32'(tbl[k].scnt));
        chk("tbl_ovr", 32'(overrun), 32'(tbl[k].ovr));
        k++;
      end
      if (t == 20) chk("s0_vld20", 32'(data_valid_z), 32'd0);
      if (t == 21) begin
        chk("s0_vld21", 32'(data_valid_z), 32'd1);
        chk("s0_dout21", 32'(data_out_z), 32'd20);
      end
      chk("sb_valid", 32'(data_valid), 32'(mv));

      data_ready = (t < 150) || (t == 212);
      if (t == 250) enable = 1'b0;

      if (mv && data_ready) begin
        if (q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          chk("sb_data", 32'(data_out), 32'(q[0]));
          void'(q.pop_front());
        end
      end
      strb = (t >= 116) && (((t - 116) % 32) == 0);
      if (strb) begin
        if (mv && !data_ready && q.size() > 0)
          void'(q.pop_front());
        q.push_back(t);
        mv = 1'b1;
      end else if (mv && data_ready) begin
        mv = 1'b0;
      end
    end
    chk("tbl_done", 32'(k), 32'd18);
    chk("sb_left", 32'(q.size()), 32'd1);

    tick();
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_rstn", 32'(cic_rst_n), 32'd0);
    chk("stop_dclk", 32'(divided_clk), 32'd0);
    chk("stop_vld", 32'(data_valid), 32'd1);
    chk("stop_dout", 32'(data_out), 32'd244);
    chk("stop_ovr", 32'(overrun), 32'd1);
    tick();
    chk("stop_vld2", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    tick();
    chk("stop_take", 32'(data_valid), 32'd0);
    data_ready = 1'b0;
    start_run(4'd5);
    chk("re_state", 32'(state), 32'd1);
    chk("re_scnt", 32'(sample_cnt), 32'd0);
    chk("re_ovr", 32'(overrun), 32'd0);

    enable = 1'b0;
    tick();
    start_run(4'd8);
    repeat (950) tick();
    dec_log2 = 4'd5;
    measure(per);
    chk("per_latched", 32'(per), 32'd256);

    for (int i = 0; i < 300 && (t % 256) != 100; i++) tick();
    chk("pre_rst_mod", 32'(t % 256), 32'd100);
    chk("pre_rst_vld", 32'(data_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_state", 32'(state), 32'd0);
    chk("mid_rstn", 32'(cic_rst_n), 32'd0);
    chk("mid_dclk", 32'(divided_clk), 32'd0);
    chk("mid_dout", 32'(data_out), 32'd0);
    chk("mid_vld", 32'(data_valid), 32'd0);
    chk("mid_ovr", 32'(overrun), 32'd0);
    chk("mid_scnt", 32'(sample_cnt), 32'd0);
    reset = 1'b0;

    start_run(4'd5);
    measure(per);
    chk("per_32", 32'(per), 32'd32);

    enable   = 1'b0;
    dec_log2 = 4'd12;
    tick();
    chk("blip_state", 32'(state), 32'd0);
    chk("blip_rstn", 32'(cic_rst_n), 32'd0);
    enable = 1'b1;
    tick();
    chk("blip_settle", 32'(state), 32'd1);
    chk("blip_scnt", 32'(sample_cnt), 32'd0);
    measure(per);
    chk("per_bad_dec", 32'(per), 32'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic3_decim_ctrl.md
# cic3_decim_ctrl

Sequencing controller for the third-order CIC decimation filter. It generates the filter's `divided_clk` from the single modulator clock, holds the filter in reset while idle and discards the unsettled start-up outputs. It also captures each settled 25-bit filter result into a valid/ready output register and flags overruns. It sits between the CIC filter and the readout/SPI logic.

## Interface
- `SETTLE`, default 3: number of post-start captures discarded (filter order). Legal range 0–7.
- `CAP_DLY`, default 4: clk cycles from the `divided_clk` rising edge to the capture of `cic_out`. Legal range 1–15.
- `clk` in 1: modulator clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: level-sensitive. High runs the filter; low returns to IDLE.
- `dec_log2` in 4: log2 of the decimation factor D. Legal values 5–8 (D = 32–256); any other value is treated as 8. Latched only on the IDLE→SETTLE transition.
- `cic_out` in 25: filter output (`out` of the CIC, `digital_monitor_sel` = 0).
- `data_ready` in 1: consumer accepts `data_out` this cycle.
- `cic_rst_n` out 1: active-low reset to the CIC filter.
- `divided_clk` out 1: decimated clock to the CIC filter, 50% duty.
- `data_out` out 25: captured filter result.
- `data_valid` out 1: `data_out` holds an unconsumed sample.
- `overrun` out 1: sticky; a new sample arrived while `data_valid` was still high.
- `sample_cnt` out 16: count of delivered (non-discarded) samples, wraps at 2^16.
- `state` out 2: current FSM state, IDLE=0, SETTLE=1, RUN=2.

## Operation
- FSM states are IDLE, SETTLE and RUN. Encoding 3 is unreachable and recovers to IDLE.
- IDLE → SETTLE: on `enable`=1. Latch `dec_log2` as D_eff. Clear `cnt`, `discard_cnt` and `sample_cnt`.
- SETTLE → RUN: when `discard_cnt` reaches SETTLE. With SETTLE=0, SETTLE is left on the next cycle, before any capture.
- Any state → IDLE: on `enable`=0, effective the next cycle.
- `cic_rst_n` = 0 in IDLE and 1 in SETTLE/RUN, registered. The filter is therefore released one cycle after leaving IDLE.
- Phase counter `cnt` (8 bits) counts 0..D−1 in SETTLE/RUN and wraps to 0. It is held at 0 in IDLE.
- `divided_clk` is registered and equals (`cnt` ≥ D/2), so it is low in IDLE.
- Capture strobe fires when `cnt` == D/2 + CAP_DLY, in SETTLE/RUN only.
- Strobe in SETTLE: the sample is discarded and `discard_cnt` is incremented.
- Strobe in RUN:
  - Register `cic_out` into `data_out`, set `data_valid`, increment `sample_cnt`.
  - If `data_valid` was already 1 and `data_ready`=0 in the same cycle, set `overrun`. The new sample overwrites the old one.
- Handshake:
  - `data_valid` clears in a cycle where `data_valid`=1, `data_ready`=1 and there is no strobe.
  - Strobe and accept in the same cycle: the old sample is consumed, the new one is loaded, `data_valid` stays 1 and there is no overrun.
- Leaving RUN for IDLE:
  - A pending `data_valid`/`data_out` is retained until consumed.
  - `overrun` is held.
  - Both are cleared on the next IDLE→SETTLE transition.
- `overrun` clears only on `reset` or on start.

## Timing
- Reset values of all outputs: `cic_rst_n`=0, `divided_clk`=0, `data_out`=0, `data_valid`=0, `overrun`=0, `sample_cnt`=0, `state`=IDLE.
- Call cycle 0 the first SETTLE cycle, which has `cnt`=0.
  - `divided_clk` rises in the cycle after `cnt` becomes D/2.
  - First strobe at cycle D/2 + CAP_DLY. Further strobes every D cycles.
  - First `data_valid` in cycle SETTLE·D + D/2 + CAP_DLY + 1.
- `dec_log2` changes during SETTLE/RUN have no effect until the next start.
- `enable` toggled 1→0→1 on consecutive cycles spends exactly one cycle in IDLE. That cycle pulses `cic_rst_n` low and fully restarts settling.
- `reset` asserted mid-frame forces IDLE on the next edge, overriding every other input.

## Test plan
- Basic run:
  - Stimulus: `reset` then `enable`=1, `dec_log2`=5, `cic_out` = the cycle number.
  - Required: `divided_clk` period 32 with 16 cycles high. Discards at cycles 20, 52 and 84. First `data_valid` at cycle 117 with `data_out`=116, then one sample every 32 cycles.
- Backpressure:
  - Stimulus: `data_ready`=0 across two strobes.
  - Required: `overrun`=1 one cycle after the second strobe, `data_out` = the newer sample.
  - Stimulus: `data_ready`=1 exactly on a strobe cycle.
  - Required: no overrun.
- Decimation latch:
  - Stimulus: start with `dec_log2`=8 and change it to 5 while in RUN.
  - Required: period stays 256.
  - Stimulus: restart.
  - Required: period 32. `dec_log2`=12 gives period 256.
- Stop/restart:
  - Stimulus: drop `enable` mid-frame while a sample is pending.
  - Required: IDLE, `cic_rst_n`=0, `divided_clk`=0. `data_valid` held until `data_ready`. On restart, `sample_cnt`=0 and `overrun`=0.
- Reset mid-operation:
  - Stimulus: `reset` pulse in RUN at `cnt`=100.
  - Required: all outputs at reset values the next cycle.
- SETTLE=0 variant:
  - Stimulus: run with SETTLE=0, `dec_log2`=5.
  - Required: the first strobe (cycle 20) is delivered, `data_valid` at cycle 21.
